pingpong_blk_writer: RTL

PINGPONG_BLK_WRITER -- requirements
Module: pingpong_blk_writer

---
 rtl/pingpong_blk_writer_pkg.sv | 23 ++
 rtl/pingpong_bank.sv | 34 +++
 rtl/pingpong_blk_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pingpong_blk_writer_pkg.sv
// Shared pingpong types and default sizes, used by the block writer and the
// 16-to-1 reader path so that both agree on bank geometry.
package pingpong_blk_writer_pkg;

   // Default sub-block width in bits.
   localparam int DW_DEF    = 8;
   // Default number of sub-blocks per bank.
   localparam int DEPTH_DEF = 16;
   // Default index width, log2(DEPTH_DEF).
   localparam int IDXW_DEF  = 4;

   // Bank identifier; the encoding doubles as the index into per-bank arrays.
   typedef enum logic {
      BANK_A = 1'b0,
      BANK_B = 1'b1
   } bank_e;

   // The other bank of the pair.
   function automatic bank_e other_bank(input bank_e b);
      return (b == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One pingpong bank: DEPTH x DW register file with a single write port and
// the whole contents exposed on a flat read bus (entry i at [i*DW +: DW]).
module pingpong_bank #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int IDXW  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                we,
   input  logic [IDXW-1:0]     widx,
   input  logic [DW-1:0]       wdata,
   output logic [DW*DEPTH-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Storage: cleared on reset, otherwise one entry written per enabled cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Flatten the storage onto the read bus.
   for (genvar g = 0; g < DEPTH; g++) begin : g_rd
      assign rdata[g*DW +: DW] = mem[g];
   end

endmodule

// File: rtl/pingpong_blk_writer.sv
// Pingpong block writer: fills two banks of DEPTH sub-blocks alternately and
// presents closed banks to a consumer, which returns them with blk_release.
// A bank closed early by in_last reports the unwritten index range so the
// consumer can pad it.
//
// Handshake: a sub-block is transferred on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on registered flags, and
// in_data/in_last are only meaningful while in_valid is high.
module pingpong_blk_writer
   import pingpong_blk_writer_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic [DW-1:0]       in_data,
   input  logic                in_last,
   output logic                in_ready,
   input  logic                blk_release,
   output logic [DW*DEPTH-1:0] a_blk,
   output logic [DW*DEPTH-1:0] b_blk,
   output logic                a_full,
   output logic                b_full,
   output logic                pingpong,
   output logic                aneedpang,
   output logic [IDXW-1:0]     aneedpangstartinc,
   output logic [IDXW-1:0]     aneedpangendinc,
   output logic                bneedpang,
   output logic [IDXW-1:0]     bneedpangstartinc,
   output logic [IDXW-1:0]     bneedpangendinc,
   output logic                dbg_wbank,
   output logic [IDXW-1:0]     dbg_wptr
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

   bank_e           wbank;
   bank_e           rd_bank;
   logic [IDXW-1:0] wptr;
   logic [1:0]      full;
   logic [1:0]      needpang;
   logic [IDXW-1:0] start_inc [2];
   logic [IDXW-1:0] end_inc   [2];

   logic            accept;
   logic            at_end;
   logic            close_bank;
   logic            release_ok;
   logic            a_we;
   logic            b_we;

   // Ready only depends on the write bank being free, never on inputs.
   assign in_ready   = !full[wbank];
   assign accept     = in_valid && in_ready;
   assign at_end     = (wptr == LAST_IDX);
   assign close_bank = accept && (at_end || in_last);
   // A release only counts while the presented bank actually holds data.
   assign release_ok = blk_release && full[rd_bank];

   assign a_we = accept && (wbank == BANK_A);
   assign b_we = accept && (wbank == BANK_B);

   // Write/read control: write pointer, bank flags, padding range, presenter.
   // A close and a release at the same edge always hit different banks,
   // because a release needs the bank full and a close needs it not full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wbank        <= BANK_A;
         rd_bank      <= BANK_A;
         wptr         <= '0;
         full         <= '0;
         needpang     <= '0;
         start_inc[0] <= '0;
         start_inc[1] <= '0;
         end_inc[0]   <= '0;
         end_inc[1]   <= '0;
      end else begin
         if (release_ok) begin
            full[rd_bank]     <= 1'b0;
            needpang[rd_bank] <= 1'b0;
            rd_bank           <= other_bank(rd_bank);
         end
         if (close_bank) begin
            full[wbank] <= 1'b1;
            wbank       <= other_bank(wbank);
            wptr        <= '0;
            if (at_end) begin
               needpang[wbank] <= 1'b0;
            end else begin
               needpang[wbank]  <= 1'b1;
               start_inc[wbank] <= wptr + IDXW'(1);
               end_inc[wbank]   <= LAST_IDX;
            end
         end else if (accept) begin
            wptr <= wptr + IDXW'(1);
         end
      end
   end

   pingpong_bank #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IDXW  (IDXW)
   ) u_bank_a (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (a_we),
      .widx    (wptr),
      .wdata   (in_data),
      .rdata   (a_blk)
   );

   pingpong_bank #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IDXW  (IDXW)
   ) u_bank_b (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (b_we),
      .widx    (wptr),
      .wdata   (in_data),
      .rdata   (b_blk)
   );

   assign a_full            = full[BANK_A];
   assign b_full            = full[BANK_B];
   assign pingpong          = (rd_bank == BANK_A);
   assign aneedpang         = needpang[BANK_A];
   assign aneedpangstartinc = start_inc[BANK_A];
   assign aneedpangendinc   = end_inc[BANK_A];
   assign bneedpang         = needpang[BANK_B];
   assign bneedpangstartinc = start_inc[BANK_B];
   assign bneedpangendinc   = end_inc[BANK_B];
   assign dbg_wbank         = wbank;
   assign dbg_wptr          = wptr;

endmodule
